cache_way_ctrl: RTL and testbench
=================================

// Module: cache_way_ctrl
// PURPOSE
//  Per-request controller for the 2-way set-associative cache datapath.
//  Samples the tag-compare hit flags and drives the sel input of the 32-bit
//  2:1 way-data mux. Keeps one LRU bit per set and picks the victim way on a miss.
//  Sequences the refill handshake with memory and keeps saturating hit/miss counters.
// PARAMETERS
//  INDEX_W  4   set-index width; SETS = 2**INDEX_W LRU bits
//  CNT_W    16  width of the hit_count and miss_count counters
// PORTS
//  clk         in   1        single clock, rising edge
//  reset       in   1        asynchronous, active-high; clears all state
//  req_valid   in   1        CPU request present
//  req_index   in   INDEX_W  set index of the request
//  req_ready   out  1        1 only in IDLE; request accepted when valid&ready
//  hit0        in   1        way-0 tag match, valid in LOOKUP
//  hit1        in   1        way-1 tag match, valid in LOOKUP
//  way_sel     out  1        drives the way-data mux sel (0 = way0, 1 = way1)
//  refill_req  out  1        refill request to memory; held until mem_ready
//  refill_way  out  1        victim way; stable while refill_req = 1
//  mem_ready   in   1        memory refill data valid (one-cycle pulse)
//  fill_we     out  2        one-hot write enable for the victim way data/tag
//  resp_valid  out  1        one-cycle pulse: data at way-mux output is valid
//  multi_hit   out  1        one-cycle pulse: hit0 & hit1 seen in LOOKUP
//  stats_clr   in   1        synchronous clear of both counters
//  hit_count   out  CNT_W    saturating count of hits
//  miss_count  out  CNT_W    saturating count of misses
// BEHAVIOUR
//  - States: IDLE, LOOKUP, REFILL, FILL, RESPOND. Reset -> IDLE.
//  - Reset values: way_sel 0, refill_req 0, refill_way 0, fill_we 00,
//    resp_valid 0, multi_hit 0, counters 0, all LRU bits 0.
//  - req_ready = (state == IDLE). It reads 1 while reset is asserted, but no
//    request is accepted during reset.
//  - IDLE: on req_valid, latch req_index into idx_q and go to LOOKUP.
//  - LOOKUP (1 cycle):
//    - Hit: way_sel <= hit1 & ~hit0. A double hit selects way0 and pulses
//      multi_hit; it still counts as one hit. hit_count++, go to RESPOND.
//    - Miss: victim = lru[idx_q]. refill_way <= victim, refill_req <= 1,
//      miss_count++, go to REFILL.
//  - REFILL: hold refill_req and refill_way. On mem_ready, refill_req <= 0
//    and go to FILL. Waiting has no timeout.
//  - FILL (1 cycle): fill_we[refill_way] = 1, way_sel <= refill_way, go to RESPOND.
//  - RESPOND (1 cycle): resp_valid = 1 with way_sel held, then go to IDLE.
//    lru[idx_q] <= ~way_sel, so the other way becomes the next victim.
//  - Latency from the accept edge to resp_valid: 2 cycles on a hit.
//    On a miss it is 3 cycles plus the mem_ready wait (mem_ready is sampled at
//    the earliest in the cycle after LOOKUP).
//  - mem_ready outside REFILL is ignored. hit0/hit1 outside LOOKUP are ignored.
//  - Counters saturate at 2**CNT_W-1.
//  - stats_clr has priority over an increment in the same cycle; the result is 0.
//  - Reset mid-operation: the FSM aborts to IDLE and refill_req drops
//    asynchronously. LRU contents are lost and reset to 0.
//  - Back-to-back requests: the next request is accepted in the first IDLE
//    cycle after RESPOND, so the minimum hit-to-hit spacing is 3 cycles.
// TESTING
//  - Reset, then idx 3 with hit1=1 -> way_sel=1, resp_valid 2 cycles after
//    accept, lru[3]=0, hit_count=1.
//  - Cold miss idx 5 -> refill_req=1, refill_way=0. mem_ready after 4 cycles
//    -> fill_we=01, resp_valid, lru[5]=1. A second miss on idx 5 -> refill_way=1.
//  - hit0=hit1=1 on idx 2 -> way_sel=0, multi_hit pulse, hit_count +1 only.
//  - Set CNT_W=2 and apply 5 hits -> hit_count sticks at 3. stats_clr together
//    with a hit -> 0.
//  - Assert reset while in REFILL -> refill_req=0 immediately, state IDLE,
//    req_ready=1 after release. The earlier miss on idx 5 now picks victim 0.
//  - mem_ready pulse in IDLE and stray hit flags in REFILL -> no state change,
//    no counter change.

Source files
------------

// File: rtl/cache_way_ctrl.sv
// cache_way_ctrl: request sequencer for a 2-way set-associative cache.
// It samples the tag-compare hit flags and steers the way-data mux.
// It keeps one LRU bit per set to choose the victim on a miss.
// It runs the refill handshake with memory and keeps saturating hit/miss counters.
module cache_way_ctrl #(
  parameter int INDEX_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  input  logic [INDEX_W-1:0] req_index,
  output logic               req_ready,
  input  logic               hit0,
  input  logic               hit1,
  output logic               way_sel,
  output logic               refill_req,
  output logic               refill_way,
  input  logic               mem_ready,
  output logic [1:0]         fill_we,
  output logic               resp_valid,
  output logic               multi_hit,
  input  logic               stats_clr,
  output logic [CNT_W-1:0]   hit_count,
  output logic [CNT_W-1:0]   miss_count
);

  localparam int SETS = 2 ** INDEX_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOOKUP  = 3'd1,
    REFILL  = 3'd2,
    FILL    = 3'd3,
    RESPOND = 3'd4
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [INDEX_W-1:0] idx_q;
  logic [SETS-1:0]    lru_q;   // per set: the way to evict on the next miss
  logic               hit_any;

  assign hit_any = hit0 | hit1;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = LOOKUP;
      LOOKUP:  state_next = hit_any ? RESPOND : REFILL;
      REFILL:  if (mem_ready) state_next = FILL;
      FILL:    state_next = RESPOND;
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs that are a pure function of the current state
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESPOND);
    fill_we    = 2'b00;
    if (state == FILL) fill_we = refill_way ? 2'b10 : 2'b01;
  end

  // Request index latch, way select, multi-hit pulse and refill handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q      <= '0;
      way_sel    <= 1'b0;
      refill_req <= 1'b0;
      refill_way <= 1'b0;
      multi_hit  <= 1'b0;
    end else begin
      multi_hit <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) idx_q <= req_index;
        end
        LOOKUP: begin
          if (hit_any) begin
            // A double hit resolves to way0 and is flagged separately
            way_sel   <= hit1 & ~hit0;
            multi_hit <= hit0 & hit1;
          end else begin
            refill_way <= lru_q[idx_q];
            refill_req <= 1'b1;
          end
        end
        REFILL: begin
          if (mem_ready) refill_req <= 1'b0;
        end
        FILL: begin
          way_sel <= refill_way;
        end
        default: ;
      endcase
    end
  end

  // LRU update: the way just served becomes most recently used
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 lru_q <= '0;
    else if (state == RESPOND) lru_q[idx_q] <= ~way_sel;
  end

  // Saturating hit/miss counters; a clear overrides a same-cycle increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (stats_clr) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == LOOKUP) begin
      if (hit_any) begin
        if (hit_count != CNT_MAX) hit_count <= hit_count + CNT_W'(1);
      end else begin
        if (miss_count != CNT_MAX) miss_count <= miss_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cache_way_ctrl.sv
// Bench for cache_way_ctrl: directed table, reset/stray-input sequences,
// then random requests checked against a set-level usage model.
module tb_cache_way_ctrl;

  localparam int IW = 4;
  localparam int CW = 16;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic [IW-1:0] req_index;
  logic          hit0, hit1, mem_ready, stats_clr;

  logic          req_ready, way_sel, refill_req, refill_way, resp_valid, multi_hit;
  logic [1:0]    fill_we;
  logic [CW-1:0] hit_count, miss_count;

  logic          s_req_ready, s_way_sel, s_refill_req, s_refill_way, s_resp_valid, s_multi_hit;
  logic [1:0]    s_fill_we;
  logic [SW-1:0] s_hit_count, s_miss_count;

  cache_way_ctrl #(.INDEX_W(IW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_index(req_index),
    .req_ready(req_ready), .hit0(hit0), .hit1(hit1), .way_sel(way_sel),
    .refill_req(refill_req), .refill_way(refill_way), .mem_ready(mem_ready),
    .fill_we(fill_we), .resp_valid(resp_valid), .multi_hit(multi_hit),
    .stats_clr(stats_clr), .hit_count(hit_count), .miss_count(miss_count)
  );

  // Small-counter instance sharing the same stimulus, for saturation
  cache_way_ctrl #(.INDEX_W(IW), .CNT_W(SW)) dut_s (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_index(req_index),
    .req_ready(s_req_ready), .hit0(hit0), .hit1(hit1), .way_sel(s_way_sel),
    .refill_req(s_refill_req), .refill_way(s_refill_way), .mem_ready(mem_ready),
    .fill_we(s_fill_we), .resp_valid(s_resp_valid), .multi_hit(s_multi_hit),
    .stats_clr(stats_clr), .hit_count(s_hit_count), .miss_count(s_miss_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: last way used per set (-1 = untouched), raw event counts
  int last_used [16];
  int m_hits, m_miss;
  int obs_way, obs_vict, obs_multi;

  typedef struct {
    int idx; bit h0; bit h1; int memwait; bit clr;
    int e_way; int e_vict; int e_multi; int e_shits;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) last_used[i] = -1;
    m_hits = 0;
    m_miss = 0;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_hits"},   hit_count,    sat(m_hits, CW));
    chk({tag, "_misses"}, miss_count,   sat(m_miss, CW));
    chk({tag, "_shits"},  s_hit_count,  sat(m_hits, SW));
    chk({tag, "_smiss"},  s_miss_count, sat(m_miss, SW));
  endtask

  // One complete request, checked against the model at every phase
  task automatic run_req(input int idx, input bit h0, input bit h1,
                         input int memwait, input bit clr);
    bit miss;
    int victim, exp_way;
    miss    = !(h0 || h1);
    victim  = (last_used[idx] < 0) ? 0 : 1 - last_used[idx];
    exp_way = miss ? victim : ((h1 && !h0) ? 1 : 0);
    obs_vict = -1;
    @(negedge clk);
    chk("req_ready", req_ready, 1);
    req_valid = 1'b1;
    req_index = IW'(idx);
    @(negedge clk);
    req_valid = 1'b0;
    hit0 = h0;
    hit1 = h1;
    stats_clr = clr;
    chk("resp_in_lookup", resp_valid, 0);
    chk("ready_in_lookup", req_ready, 0);
    @(negedge clk);
    hit0 = 1'b0;
    hit1 = 1'b0;
    stats_clr = 1'b0;
    if (clr) begin m_hits = 0; m_miss = 0; end
    else if (miss) m_miss++;
    else m_hits++;
    if (miss) begin
      chk("refill_req", refill_req, 1);
      chk("refill_way", refill_way, victim);
      chk("resp_in_refill", resp_valid, 0);
      obs_vict = int'(refill_way);
      for (int w = 0; w < memwait; w++) begin
        hit0 = 1'($urandom_range(0, 1));
        hit1 = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("refill_hold", refill_req, 1);
        chk("refill_way_stable", refill_way, victim);
        chk_counts("refill_wait");
      end
      hit0 = 1'b0;
      hit1 = 1'b0;
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      chk("refill_drop", refill_req, 0);
      chk("fill_we", fill_we, (victim == 1) ? 2 : 1);
      @(negedge clk);
    end
    chk("resp_valid", resp_valid, 1);
    chk("way_sel", way_sel, exp_way);
    chk("multi_hit", multi_hit, (h0 && h1) ? 1 : 0);
    chk("fill_we_resp", fill_we, 0);
    chk("s_resp_valid", s_resp_valid, 1);
    chk_counts("resp");
    obs_way   = int'(way_sel);
    obs_multi = int'(multi_hit);
    last_used[idx] = exp_way;
    $display("req idx=%0d h0=%0d h1=%0d clr=%0d miss=%0d way_sel=%0d hits=%0d misses=%0d",
             idx, h0, h1, clr, miss, way_sel, hit_count, miss_count);
  endtask

  initial begin
    tbl[0]  = '{3,  0, 1, 0, 0, 1, -1, 0, 1};
    tbl[1]  = '{5,  0, 0, 4, 0, 0,  0, 0, 1};
    tbl[2]  = '{5,  0, 0, 1, 0, 1,  1, 0, 1};
    tbl[3]  = '{2,  1, 1, 0, 0, 0, -1, 1, 2};
    tbl[4]  = '{3,  0, 0, 0, 0, 0,  0, 0, 2};
    tbl[5]  = '{7,  1, 0, 0, 0, 0, -1, 0, 3};
    tbl[6]  = '{8,  0, 1, 0, 0, 1, -1, 0, 3};
    tbl[7]  = '{9,  1, 0, 0, 0, 0, -1, 0, 3};
    tbl[8]  = '{10, 0, 1, 0, 0, 1, -1, 0, 3};
    tbl[9]  = '{1,  1, 0, 0, 1, 0, -1, 0, 0};
    tbl[10] = '{5,  1, 0, 0, 0, 0, -1, 0, 1};

    reset = 1'b1;
    req_valid = 1'b0; req_index = '0;
    hit0 = 1'b0; hit1 = 1'b0; mem_ready = 1'b0; stats_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_way_sel", way_sel, 0);
    chk("rst_refill_req", refill_req, 0);
    chk("rst_refill_way", refill_way, 0);
    chk("rst_fill_we", fill_we, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_multi_hit", multi_hit, 0);
    chk("rst_req_ready", req_ready, 1);
    chk_counts("rst");
    reset = 1'b0;

    // Directed table
    for (int i = 0; i < 11; i++) begin
      run_req(tbl[i].idx, tbl[i].h0, tbl[i].h1, tbl[i].memwait, tbl[i].clr);
      chk("tbl_way", obs_way, tbl[i].e_way);
      chk("tbl_multi", obs_multi, tbl[i].e_multi);
      chk("tbl_small_hits", s_hit_count, tbl[i].e_shits);
      if (tbl[i].e_vict >= 0) chk("tbl_victim", obs_vict, tbl[i].e_vict);
    end
    chk("after_clr_hits", hit_count, 1);
    chk("after_clr_misses", miss_count, 0);

    // Reset while waiting in REFILL: idx 5 would evict way1 now
    @(negedge clk);
    req_valid = 1'b1;
    req_index = 4'd5;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_refill_req", refill_req, 1);
    chk("pre_rst_refill_way", refill_way, 1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    req_valid = 1'b1;
    #1;
    chk("async_refill_drop", refill_req, 0);
    chk("rst_ready_in_reset", req_ready, 1);
    chk("rst_miss_cleared", miss_count, 0);
    @(negedge clk);
    reset = 1'b0;
    req_valid = 1'b0;
    model_reset();
    #1;
    chk("ready_after_rst", req_ready, 1);
    @(negedge clk);
    chk("still_idle_after_rst", req_ready, 1);
    run_req(5, 1'b0, 1'b0, 2, 1'b0);
    chk("victim_after_rst", obs_vict, 0);

    // Stray mem_ready while idle
    @(negedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("stray_mem_ready_idle", req_ready, 1);
    chk("stray_mem_ready_refill", refill_req, 0);
    chk("stray_mem_ready_fill_we", fill_we, 0);
    chk_counts("stray");

    // Randomized requests against the model
    for (int n = 0; n < 150; n++) begin
      run_req($urandom_range(0, 15), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 5), ($urandom_range(0, 19) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
